// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage.
// Contents: RV32M funct3 encodings (md_op_t), multiply/divide FSM states
// (md_state_t), branch funct3 codes and ALU opcodes.
package exec_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/execute_md_if.sv
// Execute-stage bus: ID/EX control and operands in, redirect/result/stall out.
// master: ID/EX side (drives inputs, sees outputs); slave: the execute stage.
interface execute_md_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_FWD    = 4
);
    localparam int SEL_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

    logic                              ValidE;
    logic                              FlushE;
    logic [3:0]                        ALUControlE;
    logic                              AluSrcE;
    logic                              JumpE;
    logic                              JalrE;
    logic                              BranchE;
    logic [2:0]                        BranchTypeE;
    logic                              MDEnE;
    logic [2:0]                        MDOpE;
    logic [DATA_WIDTH-1:0]             RD1E;
    logic [DATA_WIDTH-1:0]             RD2E;
    logic [DATA_WIDTH-1:0]             PCE;
    logic [DATA_WIDTH-1:0]             ExtImmE;
    logic [SEL_W-1:0]                  ForwardAE;
    logic [SEL_W-1:0]                  ForwardBE;
    logic [(NUM_FWD-1)*DATA_WIDTH-1:0] FwdBusE;
    logic                              PCSrcE;
    logic [DATA_WIDTH-1:0]             PCTargetE;
    logic [DATA_WIDTH-1:0]             ALUResultE;
    logic [DATA_WIDTH-1:0]             WriteDataE;
    logic                              StallE;

    modport master (
        output ValidE, FlushE, ALUControlE, AluSrcE, JumpE, JalrE, BranchE, BranchTypeE,
               MDEnE, MDOpE, RD1E, RD2E, PCE, ExtImmE, ForwardAE, ForwardBE, FwdBusE,
        input  PCSrcE, PCTargetE, ALUResultE, WriteDataE, StallE
    );

    modport slave (
        input  ValidE, FlushE, ALUControlE, AluSrcE, JumpE, JalrE, BranchE, BranchTypeE,
               MDEnE, MDOpE, RD1E, RD2E, PCE, ExtImmE, ForwardAE, ForwardBE, FwdBusE,
        output PCSrcE, PCTargetE, ALUResultE, WriteDataE, StallE
    );
endinterface

// File: rtl/alu.sv
// Integer ALU for the execute stage.
// Ports: ctrl (4-bit opcode from exec_pkg), a, b (WIDTH), y (WIDTH).
module alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (ctrl)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: y = WIDTH'(a < b);
            ALU_SLL:  y = a << sh;
            ALU_SRL:  y = a >> sh;
            ALU_SRA:  y = $signed(a) >>> sh;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide engine with its own FSM.
// Ports: clk, rst, flush (abort), start/op/a/b (issue), busy (stall request),
// done (result valid this cycle), result.
// Multiply: operands captured at issue, product registered after MUL_LATENCY
// stall cycles. Divide: restoring, one quotient bit per cycle on magnitudes.
module muldiv_unit
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MUL_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  start,
    input  md_op_t                op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(W + MUL_LATENCY + 1);

    md_state_t        state, state_nx;
    md_op_t           op_q;
    logic [W-1:0]     a_q, b_q, rem_q, res_q;
    logic [CNT_W-1:0] cnt;
    logic             q_neg, r_neg;

    function automatic logic [W-1:0] mul_fn(md_op_t f, logic [W-1:0] x, logic [W-1:0] y);
        logic [2*W-1:0] xe, ye, p;
        xe = ((f == MD_MULH || f == MD_MULHSU) && x[W-1]) ? {{W{1'b1}}, x} : {{W{1'b0}}, x};
        ye = (f == MD_MULH && y[W-1]) ? {{W{1'b1}}, y} : {{W{1'b0}}, y};
        p  = xe * ye;
        return (f == MD_MUL) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] neg_if(logic n, logic [W-1:0] x);
        return n ? -x : x;
    endfunction

    // Issue-time decode: op[2] = divide family, op[1] = remainder, op[0] = unsigned.
    logic is_div, is_signed, div_zero, div_ovf;
    assign is_div    = op[2];
    assign is_signed = op[2] & ~op[0];
    assign div_zero  = (b == '0);
    assign div_ovf   = is_signed && (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);

    // Restoring step: a_q doubles as the quotient shift register.
    logic [W:0]   shifted, diff;
    logic [W-1:0] quo_nx, rem_nx;
    assign shifted = {rem_q, a_q[W-1]};
    assign diff    = shifted - {1'b0, b_q};
    assign quo_nx  = {a_q[W-2:0], ~diff[W]};
    assign rem_nx  = diff[W] ? shifted[W-1:0] : diff[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy = 1'b1;
                    if (is_div)                state_nx = (div_zero || div_ovf) ? ST_DONE : ST_DIV;
                    else if (MUL_LATENCY == 1) state_nx = ST_DONE;
                    else                       state_nx = ST_MUL;
                end
            end
            ST_MUL: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = ST_DONE;
            end
            ST_DIV: begin
                busy = 1'b1;
                if (cnt == '0) state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (rst || flush) begin
            state_nx = ST_IDLE;
            busy     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= MD_MUL;
            a_q   <= '0;
            b_q   <= '0;
            rem_q <= '0;
            res_q <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                // issue edge: capture forwarded operands before sources move
                ST_IDLE: if (start && !flush) begin
                    op_q <= op;
                    if (is_div) begin
                        a_q   <= neg_if(is_signed & a[W-1], a);
                        b_q   <= neg_if(is_signed & b[W-1], b);
                        rem_q <= '0;
                        q_neg <= is_signed & (a[W-1] ^ b[W-1]);
                        r_neg <= is_signed & a[W-1];
                        cnt   <= CNT_W'(W - 1);
                        if (div_zero)     res_q <= op[1] ? a : '1;
                        else if (div_ovf) res_q <= op[1] ? '0 : a;
                    end else begin
                        a_q <= a;
                        b_q <= b;
                        cnt <= CNT_W'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);
                        if (MUL_LATENCY == 1) res_q <= mul_fn(op, a, b);
                    end
                end
                // multiply pipe: product lands on the last stall edge
                ST_MUL: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) res_q <= mul_fn(op_q, a_q, b_q);
                end
                // divide iteration: sign fix-up applied on the final bit
                ST_DIV: begin
                    a_q   <= quo_nx;
                    rem_q <= rem_nx;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == '0) res_q <= op_q[1] ? neg_if(r_neg, rem_nx) : neg_if(q_neg, quo_nx);
                end
                default: ;
            endcase
        end
    end

    assign done   = (state == ST_DONE);
    assign result = res_q;
endmodule

// File: rtl/mux.sv
// N-way one-hot-free select over a flattened bus; index i is in[i*WIDTH +: WIDTH].
// Ports: in (N*WIDTH), sel (SEL_W), out (WIDTH). Out-of-range select gives 0.
module mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]   sel,
    output logic [WIDTH-1:0]   out
);
    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) out = in[i*WIDTH +: WIDTH];
        end
    end
endmodule

// File: rtl/execute_md.sv
// Execute stage: NUM_FWD-way operand forwarding, ALU, RV32 branch compare,
// JAL/JALR target generation and an RV32M multiply/divide unit.
// Ports: clk, rst (sync, active-high), ex (execute_md_if.slave) carrying the
// ID/EX inputs and PCSrcE/PCTargetE/ALUResultE/WriteDataE/StallE outputs.
// StallE freezes F/D/E while a multi-cycle MD op runs; the MD result replaces
// the ALU result in the cycle the op completes.
module execute_md
    import exec_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_FWD     = 4,
    parameter int MUL_LATENCY = 2
) (
    input logic         clk,
    input logic         rst,
    execute_md_if.slave ex
);
    localparam int W     = DATA_WIDTH;
    localparam int SEL_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

    logic [W-1:0] src_a, src_b, wdata, alu_y, md_res;
    logic         md_busy, md_done, md_start, cond;

    // Source 0 is the register file; sources 1.. come from FwdBusE.
    mux #(.WIDTH(W), .N(NUM_FWD), .SEL_W(SEL_W)) u_fwd_a (
        .in ({ex.FwdBusE, ex.RD1E}),
        .sel(ex.ForwardAE),
        .out(src_a)
    );

    mux #(.WIDTH(W), .N(NUM_FWD), .SEL_W(SEL_W)) u_fwd_b (
        .in ({ex.FwdBusE, ex.RD2E}),
        .sel(ex.ForwardBE),
        .out(wdata)
    );

    assign src_b = ex.AluSrcE ? ex.ExtImmE : wdata;

    alu #(.WIDTH(W)) u_alu (
        .ctrl(ex.ALUControlE),
        .a   (src_a),
        .b   (src_b),
        .y   (alu_y)
    );

    always_comb begin
        cond = 1'b0;
        case (ex.BranchTypeE)
            BR_EQ:   cond = (src_a == src_b);
            BR_NE:   cond = (src_a != src_b);
            BR_LT:   cond = ($signed(src_a) <  $signed(src_b));
            BR_GE:   cond = ($signed(src_a) >= $signed(src_b));
            BR_LTU:  cond = (src_a <  src_b);
            BR_GEU:  cond = (src_a >= src_b);
            default: cond = 1'b0;
        endcase
    end

    assign ex.PCSrcE    = ex.ValidE & ~ex.FlushE & (ex.JumpE | (ex.BranchE & cond));
    assign ex.PCTargetE = ex.JalrE ? ((src_a + ex.ExtImmE) & ~W'(1)) : (ex.PCE + ex.ExtImmE);

    assign md_start = ex.ValidE & ex.MDEnE & ~ex.FlushE;

    muldiv_unit #(.DATA_WIDTH(W), .MUL_LATENCY(MUL_LATENCY)) u_md (
        .clk   (clk),
        .rst   (rst),
        .flush (ex.FlushE),
        .start (md_start),
        .op    (md_op_t'(ex.MDOpE)),
        .a     (src_a),
        .b     (wdata),
        .busy  (md_busy),
        .done  (md_done),
        .result(md_res)
    );

    assign ex.ALUResultE = md_done ? md_res : alu_y;
    assign ex.WriteDataE = wdata;
    assign ex.StallE     = md_busy;
endmodule

// File: tb/tb_execute_md.sv
// Directed testbench for execute_md: forwarding, branches, JALR, MUL/DIV
// latency and results, divide corner cases, flush and reset aborts.
module tb_execute_md;
    import exec_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_md_if #(.DATA_WIDTH(32), .NUM_FWD(4)) bus ();

    execute_md #(.DATA_WIDTH(32), .NUM_FWD(4), .MUL_LATENCY(2)) dut (
        .clk(clk),
        .rst(rst),
        .ex (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [2:0] br_type [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011};
    logic       br_exp  [8] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};

    task automatic clear_inputs();
        bus.ValidE      = 1'b0;
        bus.FlushE      = 1'b0;
        bus.ALUControlE = ALU_ADD;
        bus.AluSrcE     = 1'b0;
        bus.JumpE       = 1'b0;
        bus.JalrE       = 1'b0;
        bus.BranchE     = 1'b0;
        bus.BranchTypeE = 3'b000;
        bus.MDEnE       = 1'b0;
        bus.MDOpE       = 3'b000;
        bus.RD1E        = '0;
        bus.RD2E        = '0;
        bus.PCE         = '0;
        bus.ExtImmE     = '0;
        bus.ForwardAE   = '0;
        bus.ForwardBE   = '0;
        bus.FwdBusE     = '0;
    endtask

    // Issues one MD op, counts stall cycles (bounded), returns the DONE-cycle result.
    // Register operands are scrambled after issue to show they were captured.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stalls, output logic [31:0] res);
        @(negedge clk);
        clear_inputs();
        bus.ValidE = 1'b1;
        bus.MDEnE  = 1'b1;
        bus.MDOpE  = op;
        bus.RD1E   = a;
        bus.RD2E   = b;
        #1;
        stalls = 0;
        while (bus.StallE === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge clk);
            bus.RD1E = 32'hDEAD_BEEF;
            bus.RD2E = 32'h1234_5678;
            #1;
        end
        res = bus.ALUResultE;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.ValidE = 1'b1;
        bus.MDEnE  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", bus.StallE); end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1;
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL post_reset_stall: got %b expected 0", bus.StallE); end
        total++; if (bus.PCSrcE !== 1'b0) begin bad++; $display("FAIL post_reset_pcsrc: got %b expected 0", bus.PCSrcE); end
        total++; if (bus.ALUResultE !== 32'h0) begin bad++; $display("FAIL post_reset_result: got %h expected 0", bus.ALUResultE); end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        bus.ValidE      = 1'b1;
        bus.RD1E        = 32'd5;
        bus.RD2E        = 32'd7;
        bus.FwdBusE     = {32'h0000_00CC, 32'h0000_0010, 32'h0000_00AB};
        bus.ForwardAE   = 2'd2;
        bus.ALUControlE = ALU_ADD;
        bus.ExtImmE     = 32'd3;
        bus.AluSrcE     = 1'b1;
        #1;
        total++; if (bus.ALUResultE !== 32'h13) begin bad++; $display("FAIL fwd_src2_add: got %h expected 13", bus.ALUResultE); end
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL fwd_stall: got %b expected 0", bus.StallE); end
        bus.ForwardAE = 2'd0; #1;
        total++; if (bus.ALUResultE !== 32'h8) begin bad++; $display("FAIL fwd_rf_add: got %h expected 8", bus.ALUResultE); end
        bus.ForwardAE = 2'd3; #1;
        total++; if (bus.ALUResultE !== 32'hCF) begin bad++; $display("FAIL fwd_src3_add: got %h expected cf", bus.ALUResultE); end
        bus.ForwardBE = 2'd1; #1;
        total++; if (bus.WriteDataE !== 32'hAB) begin bad++; $display("FAIL fwd_b_src1: got %h expected ab", bus.WriteDataE); end
        bus.ForwardBE = 2'd0; #1;
        total++; if (bus.WriteDataE !== 32'h7) begin bad++; $display("FAIL fwd_b_rf: got %h expected 7", bus.WriteDataE); end
        bus.ForwardAE = 2'd0; bus.ForwardBE = 2'd1; bus.AluSrcE = 1'b0; bus.ALUControlE = ALU_SUB; #1;
        total++; if (bus.ALUResultE !== 32'hFFFF_FF5A) begin bad++; $display("FAIL fwd_sub_b: got %h expected ffffff5a", bus.ALUResultE); end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        bus.ValidE  = 1'b1;
        bus.BranchE = 1'b1;
        bus.RD1E    = 32'hFFFF_FFFF;
        bus.RD2E    = 32'd1;
        bus.PCE     = 32'h0000_1000;
        bus.ExtImmE = 32'h0000_0020;
        for (int i = 0; i < 8; i++) begin
            bus.BranchTypeE = br_type[i];
            #1;
            total++;
            if (bus.PCSrcE !== br_exp[i]) begin
                bad++; $display("FAIL branch_f3_%b: got %b expected %b", br_type[i], bus.PCSrcE, br_exp[i]);
            end
        end
        bus.BranchTypeE = BR_LT; #1;
        total++; if (bus.PCTargetE !== 32'h0000_1020) begin bad++; $display("FAIL branch_target: got %h expected 1020", bus.PCTargetE); end
        bus.FlushE = 1'b1; #1;
        total++; if (bus.PCSrcE !== 1'b0) begin bad++; $display("FAIL branch_flushed: got %b expected 0", bus.PCSrcE); end
        bus.FlushE = 1'b0; bus.ValidE = 1'b0; #1;
        total++; if (bus.PCSrcE !== 1'b0) begin bad++; $display("FAIL branch_invalid: got %b expected 0", bus.PCSrcE); end
    endtask

    task automatic test_jalr();
        @(negedge clk);
        clear_inputs();
        bus.ValidE  = 1'b1;
        bus.JumpE   = 1'b1;
        bus.JalrE   = 1'b1;
        bus.RD1E    = 32'h0000_0101;
        bus.ExtImmE = 32'd4;
        bus.PCE     = 32'h0000_2000;
        #1;
        total++; if (bus.PCSrcE !== 1'b1) begin bad++; $display("FAIL jalr_pcsrc: got %b expected 1", bus.PCSrcE); end
        total++; if (bus.PCTargetE !== 32'h0000_0104) begin bad++; $display("FAIL jalr_target: got %h expected 104", bus.PCTargetE); end
        bus.JalrE = 1'b0; #1;
        total++; if (bus.PCTargetE !== 32'h0000_2004) begin bad++; $display("FAIL jal_target: got %h expected 2004", bus.PCTargetE); end
    endtask

    task automatic test_mul();
        int st;
        logic [31:0] r;
        run_md(MD_MULHU, 32'hFFFF_FFFF, 32'd2, st, r);
        total++; if (st !== 2) begin bad++; $display("FAIL mulhu_stalls: got %0d expected 2", st); end
        total++; if (r !== 32'h1) begin bad++; $display("FAIL mulhu_result: got %h expected 1", r); end
        run_md(MD_MULH, 32'hFFFF_FFFF, 32'd2, st, r);
        total++; if (st !== 2) begin bad++; $display("FAIL mulh_stalls: got %0d expected 2", st); end
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulh_result: got %h expected ffffffff", r); end
        run_md(MD_MUL, 32'hFFFF_FFFF, 32'd2, st, r);
        total++; if (r !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_result: got %h expected fffffffe", r); end
        run_md(MD_MULHSU, 32'hFFFF_FFFF, 32'd2, st, r);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mulhsu_result: got %h expected ffffffff", r); end
    endtask

    task automatic test_div();
        int st;
        logic [31:0] r;
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, st, r);
        total++; if (st !== 33) begin bad++; $display("FAIL div_stalls: got %0d expected 33", st); end
        total++; if (r !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_result: got %h expected fffffffd", r); end
        run_md(MD_REM, 32'hFFFF_FFF9, 32'd2, st, r);
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rem_result: got %h expected ffffffff", r); end
        run_md(MD_DIVU, 32'd100, 32'd7, st, r);
        total++; if (st !== 33) begin bad++; $display("FAIL divu_stalls: got %0d expected 33", st); end
        total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_result: got %h expected e", r); end
        run_md(MD_REMU, 32'd100, 32'd7, st, r);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_result: got %h expected 2", r); end
        run_md(MD_DIVU, 32'd7, 32'd0, st, r);
        total++; if (st !== 1) begin bad++; $display("FAIL divz_stalls: got %0d expected 1", st); end
        total++; if (r !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divz_result: got %h expected ffffffff", r); end
        run_md(MD_REMU, 32'd7, 32'd0, st, r);
        total++; if (r !== 32'd7) begin bad++; $display("FAIL remz_result: got %h expected 7", r); end
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, r);
        total++; if (st !== 1) begin bad++; $display("FAIL ovf_div_stalls: got %0d expected 1", st); end
        total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL ovf_div_result: got %h expected 80000000", r); end
        run_md(MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, st, r);
        total++; if (st !== 1) begin bad++; $display("FAIL ovf_rem_stalls: got %0d expected 1", st); end
        total++; if (r !== 32'h0) begin bad++; $display("FAIL ovf_rem_result: got %h expected 0", r); end
    endtask

    task automatic test_abort();
        int st;
        logic [31:0] r;
        @(negedge clk);
        clear_inputs();
        bus.ValidE = 1'b1; bus.MDEnE = 1'b1; bus.MDOpE = MD_DIVU;
        bus.RD1E = 32'd100; bus.RD2E = 32'd7;
        #1;
        total++; if (bus.StallE !== 1'b1) begin bad++; $display("FAIL abort_issue_stall: got %b expected 1", bus.StallE); end
        repeat (9) @(negedge clk);
        bus.FlushE = 1'b1; #1;
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL abort_flush_stall: got %b expected 0", bus.StallE); end
        @(negedge clk);
        clear_inputs();
        bus.ValidE = 1'b1; bus.RD1E = 32'd20; bus.ExtImmE = 32'd22; bus.AluSrcE = 1'b1; #1;
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL abort_add_stall: got %b expected 0", bus.StallE); end
        total++; if (bus.ALUResultE !== 32'd42) begin bad++; $display("FAIL abort_add_result: got %h expected 2a", bus.ALUResultE); end
        // reset in the middle of a multiply
        @(negedge clk);
        clear_inputs();
        bus.ValidE = 1'b1; bus.MDEnE = 1'b1; bus.MDOpE = MD_MULHU;
        bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd2;
        @(negedge clk);
        rst = 1'b1; #1;
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL rst_mid_mul_stall: got %b expected 0", bus.StallE); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs(); #1;
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL after_rst_stall: got %b expected 0", bus.StallE); end
        total++; if (bus.ALUResultE !== 32'h0) begin bad++; $display("FAIL after_rst_result: got %h expected 0", bus.ALUResultE); end
        bus.MDEnE = 1'b1; #1;
        total++; if (bus.StallE !== 1'b0) begin bad++; $display("FAIL md_not_valid_stall: got %b expected 0", bus.StallE); end
        run_md(MD_MUL, 32'd3, 32'd5, st, r);
        total++; if (st !== 2) begin bad++; $display("FAIL post_abort_mul_stalls: got %0d expected 2", st); end
        total++; if (r !== 32'd15) begin bad++; $display("FAIL post_abort_mul_result: got %h expected f", r); end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_branch();
        test_jalr();
        test_mul();
        test_div();
        test_abort();
        @(negedge clk);
        clear_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
